// File: rtl/vp_stream_mux_pkg.sv
// Shared types for the vision-pipeline output selector.
// Imported by the selector and its synchroniser.
package vp_stream_mux_pkg;

   typedef enum logic [1:0] {
      ST_RUN     = 2'd0,
      ST_PENDING = 2'd1,
      ST_ALIGN   = 2'd2
   } state_e;

   localparam int SETTLE_W = 4;

   typedef logic [SETTLE_W-1:0] settle_t;

endpackage

// File: rtl/vp_stream_mux_sync_ff.sv
// Multi-flop synchroniser for a slow asynchronous bus.
// Bits are not coherent across the bus during a change.
module vp_stream_mux_sync_ff
   import vp_stream_mux_pkg::*;
#(
   parameter int WIDTH = 1,
   parameter int DEPTH = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [DEPTH-1:0][WIDTH-1:0] stage_q;
   logic [DEPTH-1:0][WIDTH-1:0] stage_d;

   // shift the input one stage deeper each cycle
   always_comb begin
      stage_d = {stage_q[DEPTH-2:0], d};
   end

   // synchroniser chain
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stage_q <= '0;
      end else begin
         stage_q <= stage_d;
      end
   end

   assign q = stage_q[DEPTH-1];

endmodule

// File: rtl/vp_stream_mux.sv
// Frame-synchronous registered stream selector.
// Source changes land on vsync edges; new source blanked until settled.
module vp_stream_mux
   import vp_stream_mux_pkg::*;
#(
   parameter int N_CH          = 8,
   parameter int PIX_W         = 24,
   parameter int SEL_W         = $clog2(N_CH),
   parameter int SYNC_STAGES   = 2,
   parameter int SETTLE_FRAMES = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [SEL_W-1:0]      sw,
   input  logic [N_CH-1:0]       de_in,
   input  logic [N_CH-1:0]       h_sync_in,
   input  logic [N_CH-1:0]       v_sync_in,
   input  logic [N_CH*PIX_W-1:0] pixel_in,
   output logic                  de_out,
   output logic                  h_sync_out,
   output logic                  v_sync_out,
   output logic [PIX_W-1:0]      pixel_out,
   output logic [SEL_W-1:0]      sel_active,
   output logic                  switching
);

   logic [SEL_W-1:0] sw_s;
   logic             sw_valid;
   logic [N_CH-1:0]  v_sync_q, v_sync_d;
   logic [N_CH-1:0]  vs_rise;
   logic             rise_act;
   logic             blank;

   state_e           state_q, state_d;
   logic [SEL_W-1:0] active_q, active_d;
   logic [SEL_W-1:0] target_q, target_d;
   settle_t          settle_q, settle_d;

   logic             de_q, de_d;
   logic             hs_q, hs_d;
   logic             vs_q, vs_d;
   logic [PIX_W-1:0] pix_q, pix_d;

   vp_stream_mux_sync_ff #(
      .WIDTH (SEL_W),
      .DEPTH (SYNC_STAGES)
   ) u_sw_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (sw),
      .q     (sw_s)
   );

   assign sw_valid = {1'b0, sw_s} < (SEL_W+1)'(N_CH);
   assign v_sync_d = v_sync_in;
   assign vs_rise  = v_sync_in & ~v_sync_q;
   assign rise_act = vs_rise[active_q];

   // request / frame-alignment state machine
   always_comb begin
      state_d  = state_q;
      active_d = active_q;
      target_d = target_q;
      settle_d = settle_q;
      unique case (state_q)
         ST_RUN: begin
            if (sw_valid && sw_s != active_q) begin
               target_d = sw_s;
               state_d  = ST_PENDING;
            end
         end
         ST_PENDING: begin
            if (sw_valid) target_d = sw_s;
            if (sw_valid && sw_s == active_q) begin
               state_d = ST_RUN;
            end else if (rise_act) begin
               active_d = target_q;
               settle_d = settle_t'(SETTLE_FRAMES);
               state_d  = ST_ALIGN;
            end
         end
         ST_ALIGN: begin
            if (rise_act) begin
               settle_d = settle_q - settle_t'(1);
               if (settle_q == settle_t'(1)) state_d = ST_RUN;
            end
         end
         default: state_d = ST_RUN;
      endcase
   end

   // channel mux with blanking; the last settle edge already unblanks
   always_comb begin
      blank = (state_q == ST_ALIGN) &&
              !(rise_act && settle_q == settle_t'(1));
      de_d  = de_in[active_q];
      hs_d  = h_sync_in[active_q];
      vs_d  = v_sync_in[active_q];
      pix_d = blank ? '0 : pixel_in[active_q*PIX_W +: PIX_W];
   end

   // state, edge-detect and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_RUN;
         active_q <= '0;
         target_q <= '0;
         settle_q <= '0;
         v_sync_q <= '0;
         de_q     <= 1'b0;
         hs_q     <= 1'b0;
         vs_q     <= 1'b0;
         pix_q    <= '0;
      end else begin
         state_q  <= state_d;
         active_q <= active_d;
         target_q <= target_d;
         settle_q <= settle_d;
         v_sync_q <= v_sync_d;
         de_q     <= de_d;
         hs_q     <= hs_d;
         vs_q     <= vs_d;
         pix_q    <= pix_d;
      end
   end

   assign de_out     = de_q;
   assign h_sync_out = hs_q;
   assign v_sync_out = vs_q;
   assign pixel_out  = pix_q;
   assign sel_active = active_q;
   assign switching  = (state_q != ST_RUN);

endmodule
